// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: synchronises din, measures high/low run lengths,
// decodes MSB-first 24-bit words and reports frame gaps and protocol errors.
module ws2812_rx #(
    parameter int CLK_MHZ    = 12,
    parameter int NUM_LEDS   = 8,
    parameter int T_THRESH   = (CLK_MHZ*600+999)/1000,
    parameter int T_MIN_HIGH = (CLK_MHZ*150+999)/1000,
    parameter int T_HIGH_MAX = CLK_MHZ*5,
    parameter int T_RESET    = CLK_MHZ*50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic [23:0] rgb_data,
    output logic [7:0]  led_num,
    output logic        valid,
    output logic        frame_done,
    output logic [7:0]  frame_leds,
    output logic        err
);
    // Counters are one value wider than needed so saturation never sits on a threshold.
    localparam int HW = $clog2(T_HIGH_MAX+2);
    localparam int LW = $clog2(T_RESET+2);

    localparam logic [1:0] ST_SYNC = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    logic          s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
    logic          rise_q, rise_d, fall_q, fall_d;
    logic [HW-1:0] hi_cnt_q, hi_cnt_d, pulse_len_q, pulse_len_d;
    logic [LW-1:0] lo_cnt_q, lo_cnt_d;
    logic [1:0]    state_q, state_d;
    logic [22:0]   shift_q, shift_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    word_cnt_q, word_cnt_d;
    logic [23:0]   rgb_q, rgb_d;
    logic [7:0]    led_num_q, led_num_d, frame_leds_q, frame_leds_d;
    logic          valid_q, valid_d, frame_done_q, frame_done_d, err_q, err_d;
    logic          bit_val;

    // Edge events are registered and the high width latched at the fall, so the
    // FSM sees a stable pulse length after hi_cnt has already cleared.
    always_comb begin
        s1_d        = din;
        s2_d        = s1_q;
        prev_d      = s2_q;
        rise_d      = s2_q & ~prev_q;
        fall_d      = ~s2_q & prev_q;
        hi_cnt_d    = s2_q ? ((hi_cnt_q == '1) ? hi_cnt_q : hi_cnt_q + HW'(1)) : '0;
        lo_cnt_d    = !s2_q ? ((lo_cnt_q == '1) ? lo_cnt_q : lo_cnt_q + LW'(1)) : '0;
        pulse_len_d = fall_d ? hi_cnt_q : pulse_len_q;
    end

    assign bit_val = (pulse_len_q >= HW'(T_THRESH));

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        rgb_d        = rgb_q;
        led_num_d    = led_num_q;
        frame_leds_d = frame_leds_q;
        valid_d      = 1'b0;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (lo_cnt_q == LW'(T_RESET)) begin
                    state_d    = ST_LOW;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                end
            end
            ST_LOW: begin
                if (rise_q) begin
                    state_d = ST_HIGH;
                end else if (lo_cnt_q == LW'(T_RESET)) begin
                    frame_done_d = 1'b1;
                    frame_leds_d = word_cnt_q;
                    err_d        = (bit_cnt_q != '0);
                    word_cnt_d   = '0;
                    bit_cnt_d    = '0;
                end
            end
            ST_HIGH: begin
                if (hi_cnt_q > HW'(T_HIGH_MAX)) begin
                    err_d      = 1'b1;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    state_d    = ST_SYNC;
                end else if (fall_q) begin
                    state_d = ST_LOW;
                    if (pulse_len_q < HW'(T_MIN_HIGH)) begin
                        err_d = 1'b1;
                    end else if (bit_cnt_q == 5'd23) begin
                        bit_cnt_d = '0;
                        if (word_cnt_q < 8'(NUM_LEDS)) begin
                            rgb_d      = {shift_q, bit_val};
                            led_num_d  = word_cnt_q;
                            valid_d    = 1'b1;
                            word_cnt_d = word_cnt_q + 8'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        shift_d   = {shift_q[21:0], bit_val};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            prev_q       <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            hi_cnt_q     <= '0;
            lo_cnt_q     <= '0;
            pulse_len_q  <= '0;
            state_q      <= ST_SYNC;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            rgb_q        <= '0;
            led_num_q    <= '0;
            frame_leds_q <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            prev_q       <= prev_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            hi_cnt_q     <= hi_cnt_d;
            lo_cnt_q     <= lo_cnt_d;
            pulse_len_q  <= pulse_len_d;
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            rgb_q        <= rgb_d;
            led_num_q    <= led_num_d;
            frame_leds_q <= frame_leds_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign rgb_data   = rgb_q;
    assign led_num    = led_num_q;
    assign valid      = valid_q;
    assign frame_done = frame_done_q;
    assign frame_leds = frame_leds_q;
    assign err        = err_q;
endmodule
